exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the five-stage LoongArch pipeline, placed between decode and memory. It latches the 155-bit decode bus and the 8-bit memory-instruction bus. It computes ALU, multiply and iterative-divide results, issues the data-SRAM request, and forwards its destination register to decode. Divides occupy the stage for multiple cycles under valid/allowin back-pressure.

## Interface
- Parameters: none; all widths come from the shared package.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `ds_to_es_valid` in 1: decode has an instruction.
- `es_allowin` out 1: stage can accept an instruction.
- `ds_to_es_bus` in 155, fields MSB→LSB:
  - alu_op[18:0] = {mul_w, mulh_w, mulh_wu, div_w, mod_w, div_wu, mod_wu, op12[11:0]}
  - res_from_mem, src1[31:0], src2[31:0], st_en, rf_we, waddr[4:0], rkd[31:0], pc[31:0]
- `mem_inst_bus` in 8: {ld_w, ld_h, ld_hu, ld_b, ld_bu, st_w, st_h, st_b}.
- `ms_allowin` in 1: memory stage can accept.
- `es_to_ms_valid` out 1: result handed to memory stage.
- `es_to_ms_bus` out 78: {ld_w, ld_h, ld_hu, ld_b, ld_bu, addr_lo[1:0], res_from_mem, rf_we, waddr[4:0], result[31:0], pc[31:0]}.
- `es_rf_collect` out 39: {not_ready, rf_we&es_valid, waddr, result}.
- `data_sram_en` out 1: SRAM request.
- `data_sram_we` out 4: byte strobes.
- `data_sram_addr` out 32: request address.
- `data_sram_wdata` out 32: write data.

## Operation
- Stage register:
  - `es_valid` loads `ds_to_es_valid` when `es_allowin`.
  - Bus fields latch on `ds_to_es_valid & es_allowin`; otherwise they hold.
  - `es_allowin = ~es_valid | es_ready_go & ms_allowin`.
  - `es_to_ms_valid = es_valid & es_ready_go`.
- op12 ALU, one-hot:
  - [0] add, [1] sub, [2] slt (signed), [3] sltu.
  - [4] and, [5] nor, [6] or, [7] xor.
  - [8] sll, [9] srl, [10] sra; shift amount is src2[4:0].
  - [11] lu12i; result = src2.
- Multiply, combinational, single cycle:
  - mul_w: low 32 bits of signed product.
  - mulh_w: high 32 bits of signed 64-bit product.
  - mulh_wu: high 32 bits of unsigned 64-bit product.
- Divide via `div_iter`, radix-2 restoring on magnitudes:
  - Signed quotient is negated when operand signs differ.
  - Signed remainder takes the dividend's sign.
  - Divide by zero: quotient 0xFFFFFFFF (unsigned magnitude); remainder = dividend.
  - 0x80000000 / −1 gives quotient 0x80000000, remainder 0.
- `es_ready_go`:
  - 1 for non-divide instructions.
  - For divides, 1 only while `div_done` is held.
- Result mux: divide > multiply > ALU.
- Memory request:
  - `data_sram_addr` = ALU sum.
  - `data_sram_en = es_valid & (res_from_mem|st_en) & ms_allowin`.
- Store strobes (`data_sram_we`, zero unless `st_en & es_valid & ms_allowin`):
  - st_w: 1111.
  - st_h: addr[1] ? 1100 : 0011.
  - st_b: 0001 << addr[1:0].
- Store write data:
  - st_b: {4{rkd[7:0]}}.
  - st_h: {2{rkd[15:0]}}.
  - st_w: rkd.
- `not_ready = es_valid & (res_from_mem | divide & ~div_done)`. Decode stalls its consumer on this bit, so an unfinished quotient is never forwarded.

## Timing
- Reset is asynchronous and clears:
  - `es_valid`, the bus register, the divider state and `div_started`.
  - Resulting outputs: `es_to_ms_valid`=0, `es_allowin`=1, `data_sram_en`=0, `data_sram_we`=0, `es_rf_collect`=0.
- Non-divide instructions: 1-cycle occupancy; outputs are combinational from the stage register.
- Divide sequence (cycle 0 = first cycle `es_valid` holds the divide):
  - Cycle 0: `div_iter` captures operands when `div_started`=0; `div_started` is set.
  - Cycles 1–32: one iteration per cycle.
  - Cycle 33: `div_done`=1.
  - Minimum occupancy is 34 cycles.
- `div_done` and the result hold until the instruction leaves (`es_ready_go & ms_allowin`). Departure clears `div_started` and `div_done`.
- No restart occurs during a stall. Back-to-back divides start fresh.
- With `ms_allowin`=0, the bus, result and `es_rf_collect` are stable, and no SRAM request is issued.
- Reset mid-divide abandons the operation. The next instruction after reset behaves as if from cold.

## Structure
- Package `cpu_pkg`:
  - Bus widths: 155, 78, 39, 8.
  - Field offsets for each bus.
  - `alu_op` bit indices.
- Sub-module `div_iter` (clk, reset, start, signed, x, y → done, q, r).
- ALU and multiplier stay inline.

## Test plan
- add: src1=5, src2=7, ms_allowin=1 → result 12; `es_to_ms_valid` in the cycle after acceptance; `not_ready`=0.
- div_w −7/2: quotient 0xFFFFFFFD exactly 33 cycles after entry. mod_w −7/2 → 0xFFFFFFFF. Meanwhile `es_allowin`=0 and `not_ready`=1 throughout.
- st_b: addr 0x1003, rkd 0x12345678 → we=1000, wdata=0x78787878. st_h at addr 0x1002 → we=1100.
- mulh_wu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. mulh_w on the same operands → 0x00000000. mul_w → 0x00000001.
- div_wu 10/0 → quotient 0xFFFFFFFF; mod_wu → 10. With ms_allowin=0 for 5 cycles after done: outputs hold, one handoff occurs, and no re-divide.
- Reset asserted at cycle 10 of a divide → `es_valid`=0 immediately. A subsequent add completes in one cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, bus layouts and opcode bit indices for the LoongArch pipeline.
// Field offsets are carried by the packed struct layouts (first member = MSB).
package cpu_pkg;

  localparam int DS_TO_ES_BUS_W  = 155;
  localparam int ES_TO_MS_BUS_W  = 78;
  localparam int ES_RF_COLLECT_W = 39;
  localparam int MEM_INST_BUS_W  = 8;
  localparam int DIV_STEPS       = 32;

  // alu_op bit indices
  localparam int OP_ADD     = 0;
  localparam int OP_SUB     = 1;
  localparam int OP_SLT     = 2;
  localparam int OP_SLTU    = 3;
  localparam int OP_AND     = 4;
  localparam int OP_NOR     = 5;
  localparam int OP_OR      = 6;
  localparam int OP_XOR     = 7;
  localparam int OP_SLL     = 8;
  localparam int OP_SRL     = 9;
  localparam int OP_SRA     = 10;
  localparam int OP_LU12I   = 11;
  localparam int OP_MOD_WU  = 12;
  localparam int OP_DIV_WU  = 13;
  localparam int OP_MOD_W   = 14;
  localparam int OP_DIV_W   = 15;
  localparam int OP_MULH_WU = 16;
  localparam int OP_MULH_W  = 17;
  localparam int OP_MUL_W   = 18;

  // mem_inst_bus bit indices; loads occupy [MI_LD_W:MI_LD_BU]
  localparam int MI_ST_B  = 0;
  localparam int MI_ST_H  = 1;
  localparam int MI_ST_W  = 2;
  localparam int MI_LD_BU = 3;
  localparam int MI_LD_W  = 7;

  typedef struct packed {
    logic [18:0] alu_op;
    logic        res_from_mem;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        st_en;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] rkd;
    logic [31:0] pc;
  } ds_bus_t;

  typedef struct packed {
    logic [4:0]  ld;
    logic [1:0]  addr_lo;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] result;
    logic [31:0] pc;
  } es_to_ms_bus_t;

  typedef struct packed {
    logic        not_ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] result;
  } rf_collect_t;

endpackage

// File: rtl/exe_stage_div_iter.sv
// Radix-2 restoring divider on operand magnitudes; signs are applied on the way out.
// done rises DIV_STEPS cycles after start and holds until the next start.
module div_iter
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r
);

  logic        busy, neg_q, neg_r;
  logic [4:0]  cnt;
  logic [31:0] divisor, quo, rem, diff, x_abs, y_abs;
  logic [32:0] shifted;
  logic        fits;

  assign x_abs   = (is_signed && x[31]) ? (~x + 32'd1) : x;
  assign y_abs   = (is_signed && y[31]) ? (~y + 32'd1) : y;
  assign shifted = {rem, quo[31]};
  assign fits    = shifted >= {1'b0, divisor};
  assign diff    = shifted[31:0] - divisor;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      divisor <= '0;
      quo     <= '0;
      rem     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (start) begin
      busy    <= 1'b1;
      done    <= 1'b0;
      cnt     <= '0;
      divisor <= y_abs;
      quo     <= x_abs;
      rem     <= '0;
      neg_q   <= is_signed & (x[31] ^ y[31]);
      neg_r   <= is_signed & x[31];
    end else if (busy) begin
      cnt <= cnt + 5'd1;
      rem <= fits ? diff : shifted[31:0];
      quo <= {quo[30:0], fits};
      if (cnt == 5'(DIV_STEPS - 1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign q = neg_q ? (~quo + 32'd1) : quo;
  assign r = neg_r ? (~rem + 32'd1) : rem;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, single-cycle multiply, iterative divide, data-SRAM request
// and destination forwarding to decode, under valid/allowin handshaking.
module exe_stage
  import cpu_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_to_es_valid,
  output logic                       es_allowin,
  input  logic [DS_TO_ES_BUS_W-1:0]  ds_to_es_bus,
  input  logic [MEM_INST_BUS_W-1:0]  mem_inst_bus,
  input  logic                       ms_allowin,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_W-1:0]  es_to_ms_bus,
  output logic [ES_RF_COLLECT_W-1:0] es_rf_collect,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  ds_bus_t                   ds;
  logic [MEM_INST_BUS_W-1:0] mi;
  logic        es_valid, es_ready_go, es_leave;
  logic        div_started, div_start, div_done_raw, div_done;
  logic        is_div, is_mul, div_signed, div_rem, mul_signed;
  logic [11:0] op;
  logic [31:0] src1, src2, sum, sra_res, alu_result, mul_result, div_q, div_r, result;
  logic signed [31:0] src1_s;
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] product;
  logic [3:0]  store_strb;
  es_to_ms_bus_t ms_bus;
  rf_collect_t   rf_bus;

  assign es_leave       = es_valid & es_ready_go & ms_allowin;
  assign es_allowin     = ~es_valid | es_ready_go & ms_allowin;
  assign es_to_ms_valid = es_valid & es_ready_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           es_valid <= 1'b0;
    else if (es_allowin) es_valid <= ds_to_es_valid;
  end

  // NOTE: the bus register is a datapath register but is still reset, so forwarded fields read zero from cold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds <= '0;
      mi <= '0;
    end else if (ds_to_es_valid & es_allowin) begin
      ds <= ds_bus_t'(ds_to_es_bus);
      mi <= mem_inst_bus;
    end
  end

  assign op      = ds.alu_op[11:0];
  assign src1    = ds.src1;
  assign src2    = ds.src2;
  assign src1_s  = ds.src1;
  assign sum     = src1 + src2;
  assign sra_res = src1_s >>> src2[4:0];

  assign alu_result = ({32{op[OP_ADD]}}   & sum)
                    | ({32{op[OP_SUB]}}   & (src1 - src2))
                    | ({32{op[OP_SLT]}}   & {31'd0, $signed(src1) < $signed(src2)})
                    | ({32{op[OP_SLTU]}}  & {31'd0, src1 < src2})
                    | ({32{op[OP_AND]}}   & (src1 & src2))
                    | ({32{op[OP_NOR]}}   & ~(src1 | src2))
                    | ({32{op[OP_OR]}}    & (src1 | src2))
                    | ({32{op[OP_XOR]}}   & (src1 ^ src2))
                    | ({32{op[OP_SLL]}}   & (src1 << src2[4:0]))
                    | ({32{op[OP_SRL]}}   & (src1 >> src2[4:0]))
                    | ({32{op[OP_SRA]}}   & sra_res)
                    | ({32{op[OP_LU12I]}} & src2);

  // One 33x33 signed multiplier serves both signed and unsigned high halves.
  assign is_mul     = |ds.alu_op[OP_MUL_W:OP_MULH_WU];
  assign mul_signed = ~ds.alu_op[OP_MULH_WU];
  assign mul_a      = {mul_signed & src1[31], src1};
  assign mul_b      = {mul_signed & src2[31], src2};
  assign product    = 64'(mul_a) * 64'(mul_b);
  assign mul_result = ds.alu_op[OP_MUL_W] ? product[31:0] : product[63:32];

  assign is_div     = |ds.alu_op[OP_DIV_W:OP_MOD_WU];
  assign div_signed = ds.alu_op[OP_DIV_W] | ds.alu_op[OP_MOD_W];
  assign div_rem    = ds.alu_op[OP_MOD_W] | ds.alu_op[OP_MOD_WU];
  assign div_start  = es_valid & is_div & ~div_started;
  // The divider's done flag outlives the instruction; only trust it while this one owns it.
  assign div_done   = div_done_raw & div_started;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          div_started <= 1'b0;
    else if (es_leave)  div_started <= 1'b0;
    else if (div_start) div_started <= 1'b1;
  end

  div_iter u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .is_signed (div_signed),
    .x         (src1),
    .y         (src2),
    .done      (div_done_raw),
    .q         (div_q),
    .r         (div_r)
  );

  assign es_ready_go = ~is_div | div_done;
  assign result      = is_div ? (div_rem ? div_r : div_q)
                     : is_mul ? mul_result : alu_result;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    store_strb = 4'b0000;
    if (mi[MI_ST_W])      store_strb = 4'b1111;
    else if (mi[MI_ST_H]) store_strb = sum[1] ? 4'b1100 : 4'b0011;
    else if (mi[MI_ST_B]) store_strb = 4'b0001 << sum[1:0];
  end

  assign data_sram_en    = es_valid & (ds.res_from_mem | ds.st_en) & ms_allowin;
  assign data_sram_we    = (ds.st_en & es_valid & ms_allowin) ? store_strb : 4'b0000;
  assign data_sram_addr  = sum;
  assign data_sram_wdata = mi[MI_ST_B] ? {4{ds.rkd[7:0]}}
                         : mi[MI_ST_H] ? {2{ds.rkd[15:0]}} : ds.rkd;

  assign ms_bus.ld           = mi[MI_LD_W:MI_LD_BU];
  assign ms_bus.addr_lo      = sum[1:0];
  assign ms_bus.res_from_mem = ds.res_from_mem;
  assign ms_bus.rf_we        = ds.rf_we;
  assign ms_bus.waddr        = ds.waddr;
  assign ms_bus.result       = result;
  assign ms_bus.pc           = ds.pc;
  assign es_to_ms_bus        = ms_bus;

  assign rf_bus.not_ready = es_valid & (ds.res_from_mem | is_div & ~div_done);
  assign rf_bus.we        = ds.rf_we & es_valid;
  assign rf_bus.waddr     = ds.waddr;
  assign rf_bus.result    = result;
  assign es_rf_collect    = rf_bus;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU, multiply, divide timing, stores, stalls and reset.
module tb_exe_stage;

  localparam logic [18:0] A_ADD     = 19'h00001;
  localparam logic [18:0] A_SUB     = 19'h00002;
  localparam logic [18:0] A_SLT     = 19'h00004;
  localparam logic [18:0] A_SLTU    = 19'h00008;
  localparam logic [18:0] A_AND     = 19'h00010;
  localparam logic [18:0] A_NOR     = 19'h00020;
  localparam logic [18:0] A_OR      = 19'h00040;
  localparam logic [18:0] A_XOR     = 19'h00080;
  localparam logic [18:0] A_SLL     = 19'h00100;
  localparam logic [18:0] A_SRL     = 19'h00200;
  localparam logic [18:0] A_SRA     = 19'h00400;
  localparam logic [18:0] A_LU12I   = 19'h00800;
  localparam logic [18:0] A_MOD_WU  = 19'h01000;
  localparam logic [18:0] A_DIV_WU  = 19'h02000;
  localparam logic [18:0] A_MOD_W   = 19'h04000;
  localparam logic [18:0] A_DIV_W   = 19'h08000;
  localparam logic [18:0] A_MULH_WU = 19'h10000;
  localparam logic [18:0] A_MULH_W  = 19'h20000;
  localparam logic [18:0] A_MUL_W   = 19'h40000;

  logic         clk = 1'b0;
  logic         reset;
  logic         ds_to_es_valid;
  logic         es_allowin;
  logic [154:0] ds_to_es_bus;
  logic [7:0]   mem_inst_bus;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [77:0]  es_to_ms_bus;
  logic [38:0]  es_rf_collect;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int total = 0;
  int bad   = 0;

  exe_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_to_es_valid  (ds_to_es_valid),
    .es_allowin      (es_allowin),
    .ds_to_es_bus    (ds_to_es_bus),
    .mem_inst_bus    (mem_inst_bus),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_rf_collect   (es_rf_collect),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [154:0] mk(input logic [18:0] aop, input logic rfm,
                                      input logic [31:0] s1, input logic [31:0] s2,
                                      input logic st, input logic we, input logic [4:0] wa,
                                      input logic [31:0] rkd, input logic [31:0] pc);
    return {aop, rfm, s1, s2, st, we, wa, rkd, pc};
  endfunction

  // Called while clk is low; returns just after the accepting edge (cycle 0 of the instruction).
  task automatic send(input logic [154:0] bus, input logic [7:0] mi);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = bus;
    mem_inst_bus   = mi;
    total++;
    if (es_allowin !== 1'b1) begin
      bad++;
      $display("FAIL send_allowin: es_allowin=%b want 1", es_allowin);
    end
    @(posedge clk);
    #1;
    ds_to_es_valid = 1'b0;
  endtask

  task automatic run_div(input logic [18:0] aop, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input string name);
    int stall_bad = 0;
    send(mk(aop, 1'b0, a, b, 1'b0, 1'b1, 5'd9, 32'h0, 32'h1c000100), 8'h00);
    for (int k = 0; k < 33; k++) begin
      @(negedge clk);
      if (es_allowin !== 1'b0 || es_to_ms_valid !== 1'b0 || es_rf_collect[38] !== 1'b1)
        stall_bad++;
    end
    total++;
    if (stall_bad != 0) begin
      bad++;
      $display("FAIL %s_stall: %0d busy cycles with wrong allowin/valid/not_ready, want 0", name, stall_bad);
    end
    @(negedge clk);
    total++;
    if (es_to_ms_valid !== 1'b1 || es_to_ms_bus[63:32] !== want) begin
      bad++;
      $display("FAIL %s_result: valid=%b result=%h want valid=1 result=%h",
               name, es_to_ms_valid, es_to_ms_bus[63:32], want);
    end
    total++;
    if (es_rf_collect !== {1'b0, 1'b1, 5'd9, want}) begin
      bad++;
      $display("FAIL %s_fwd: rf_collect=%h want %h", name, es_rf_collect, {1'b0, 1'b1, 5'd9, want});
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; ds_to_es_valid = 1'b0; ds_to_es_bus = '0; mem_inst_bus = '0; ms_allowin = 1'b1;
    #12;
    total++;
    if (es_to_ms_valid !== 1'b0 || es_allowin !== 1'b1 || data_sram_en !== 1'b0 ||
        data_sram_we !== 4'b0 || es_rf_collect !== 39'd0) begin
      bad++;
      $display("FAIL reset_state: valid=%b allowin=%b en=%b we=%b rf=%h want 0 1 0 0 0",
               es_to_ms_valid, es_allowin, data_sram_en, data_sram_we, es_rf_collect);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add;
    ms_allowin = 1'b1;
    send(mk(A_ADD, 1'b0, 32'd5, 32'd7, 1'b0, 1'b1, 5'd3, 32'h0, 32'h1c000000), 8'h00);
    @(negedge clk);
    total++;
    if (es_to_ms_valid !== 1'b1 || es_to_ms_bus[63:32] !== 32'd12) begin
      bad++;
      $display("FAIL add_result: valid=%b result=%h want valid=1 result=0000000c",
               es_to_ms_valid, es_to_ms_bus[63:32]);
    end
    total++;
    if (es_rf_collect !== {1'b0, 1'b1, 5'd3, 32'd12}) begin
      bad++;
      $display("FAIL add_fwd: rf_collect=%h want %h", es_rf_collect, {1'b0, 1'b1, 5'd3, 32'd12});
    end
    @(negedge clk);
    total++;
    if (es_to_ms_valid !== 1'b0 || es_allowin !== 1'b1) begin
      bad++;
      $display("FAIL add_leave: valid=%b allowin=%b want 0 1", es_to_ms_valid, es_allowin);
    end
  endtask

  task automatic test_alu;
    logic [18:0] ops  [0:10] = '{A_SUB, A_SLT, A_SLTU, A_AND, A_NOR, A_OR,
                                 A_XOR, A_SLL, A_SRL, A_SRA, A_LU12I};
    logic [31:0] want [0:10] = '{32'hFFFFFFDC, 32'h00000001, 32'h00000000, 32'h00000010,
                                 32'h0000000B, 32'hFFFFFFF4, 32'hFFFFFFE4, 32'hFF000000,
                                 32'h00000FFF, 32'hFFFFFFFF, 32'h00000014};
    for (int i = 0; i < 11; i++) begin
      send(mk(ops[i], 1'b0, 32'hFFFFFFF0, 32'h00000014, 1'b0, 1'b1, 5'd4, 32'h0, 32'h0), 8'h00);
      @(negedge clk);
      total++;
      if (es_to_ms_bus[63:32] !== want[i]) begin
        bad++;
        $display("FAIL alu_%0d: result=%h want %h", i, es_to_ms_bus[63:32], want[i]);
      end
    end
  endtask

  task automatic test_mul;
    logic [18:0] ops  [0:2] = '{A_MULH_WU, A_MULH_W, A_MUL_W};
    logic [31:0] want [0:2] = '{32'hFFFFFFFE, 32'h00000000, 32'h00000001};
    for (int i = 0; i < 3; i++) begin
      send(mk(ops[i], 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 5'd5, 32'h0, 32'h0), 8'h00);
      @(negedge clk);
      total++;
      if (es_to_ms_valid !== 1'b1 || es_to_ms_bus[63:32] !== want[i]) begin
        bad++;
        $display("FAIL mul_%0d: valid=%b result=%h want valid=1 result=%h",
                 i, es_to_ms_valid, es_to_ms_bus[63:32], want[i]);
      end
    end
  endtask

  task automatic test_div;
    ms_allowin = 1'b1;
    @(negedge clk);
    run_div(A_DIV_W,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div_w");
    run_div(A_MOD_W,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "mod_w");
    run_div(A_DIV_W,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_w_ovf");
    run_div(A_MOD_W,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, "mod_w_ovf");
    run_div(A_DIV_WU, 32'd100,      32'd7,        32'd14,       "div_wu");
    run_div(A_MOD_WU, 32'd100,      32'd7,        32'd2,        "mod_wu");
  endtask

  task automatic test_div_zero_stall;
    int hold_bad = 0;
    int handoffs = 0;
    ms_allowin = 1'b1;
    @(negedge clk);
    ms_allowin = 1'b0;
    send(mk(A_DIV_WU, 1'b0, 32'd10, 32'd0, 1'b0, 1'b1, 5'd6, 32'h0, 32'h0), 8'h00);
    repeat (34) @(negedge clk);
    total++;
    if (es_to_ms_valid !== 1'b1 || es_to_ms_bus[63:32] !== 32'hFFFFFFFF || es_allowin !== 1'b0) begin
      bad++;
      $display("FAIL divz_result: valid=%b result=%h allowin=%b want 1 ffffffff 0",
               es_to_ms_valid, es_to_ms_bus[63:32], es_allowin);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (es_to_ms_valid !== 1'b1 || es_to_ms_bus[63:32] !== 32'hFFFFFFFF ||
          es_rf_collect !== {1'b0, 1'b1, 5'd6, 32'hFFFFFFFF} || es_allowin !== 1'b0 ||
          data_sram_en !== 1'b0)
        hold_bad++;
    end
    total++;
    if (hold_bad != 0) begin
      bad++;
      $display("FAIL divz_hold: %0d stalled cycles changed, want 0", hold_bad);
    end
    ms_allowin = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (es_to_ms_valid === 1'b1 && ms_allowin === 1'b1) handoffs++;
      @(negedge clk);
    end
    total++;
    if (handoffs != 1) begin
      bad++;
      $display("FAIL divz_handoff: handoffs=%0d want 1", handoffs);
    end
    run_div(A_MOD_WU, 32'd10, 32'd0, 32'd10, "modz");
  endtask

  task automatic test_store;
    ms_allowin = 1'b1;
    @(negedge clk);
    send(mk(A_ADD, 1'b0, 32'h1000, 32'h3, 1'b1, 1'b0, 5'd0, 32'h12345678, 32'h0), 8'h01);
    @(negedge clk);
    total++;
    if (data_sram_en !== 1'b1 || data_sram_we !== 4'b1000 || data_sram_wdata !== 32'h78787878 ||
        data_sram_addr !== 32'h1003 || es_to_ms_bus[72:71] !== 2'd3) begin
      bad++;
      $display("FAIL st_b: en=%b we=%b wdata=%h addr=%h lo=%0d want 1 1000 78787878 00001003 3",
               data_sram_en, data_sram_we, data_sram_wdata, data_sram_addr, es_to_ms_bus[72:71]);
    end
    send(mk(A_ADD, 1'b0, 32'h1000, 32'h2, 1'b1, 1'b0, 5'd0, 32'h12345678, 32'h0), 8'h02);
    @(negedge clk);
    total++;
    if (data_sram_we !== 4'b1100 || data_sram_wdata !== 32'h56785678) begin
      bad++;
      $display("FAIL st_h: we=%b wdata=%h want 1100 56785678", data_sram_we, data_sram_wdata);
    end
    @(negedge clk);
    ms_allowin = 1'b0;
    send(mk(A_ADD, 1'b0, 32'h1000, 32'h0, 1'b1, 1'b0, 5'd0, 32'hCAFEF00D, 32'h0), 8'h04);
    @(negedge clk);
    total++;
    if (data_sram_en !== 1'b0 || data_sram_we !== 4'b0000 || es_to_ms_valid !== 1'b1 ||
        es_allowin !== 1'b0) begin
      bad++;
      $display("FAIL st_w_blocked: en=%b we=%b valid=%b allowin=%b want 0 0000 1 0",
               data_sram_en, data_sram_we, es_to_ms_valid, es_allowin);
    end
    ms_allowin = 1'b1;
    #1;
    total++;
    if (data_sram_en !== 1'b1 || data_sram_we !== 4'b1111 || data_sram_wdata !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL st_w: en=%b we=%b wdata=%h want 1 1111 cafef00d",
               data_sram_en, data_sram_we, data_sram_wdata);
    end
    @(negedge clk);
    send(mk(A_ADD, 1'b1, 32'h2000, 32'h4, 1'b0, 1'b1, 5'd8, 32'h0, 32'h0), 8'h80);
    @(negedge clk);
    total++;
    if (data_sram_en !== 1'b1 || data_sram_we !== 4'b0000 || es_rf_collect[38] !== 1'b1 ||
        es_to_ms_bus[77:73] !== 5'b10000) begin
      bad++;
      $display("FAIL ld_w: en=%b we=%b not_ready=%b ld=%b want 1 0000 1 10000",
               data_sram_en, data_sram_we, es_rf_collect[38], es_to_ms_bus[77:73]);
    end
  endtask

  task automatic test_reset_mid_div;
    ms_allowin = 1'b1;
    @(negedge clk);
    send(mk(A_DIV_W, 1'b0, 32'd1000, 32'd3, 1'b0, 1'b1, 5'd2, 32'h0, 32'h0), 8'h00);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (es_allowin !== 1'b1 || es_to_ms_valid !== 1'b0 || es_rf_collect !== 39'd0) begin
      bad++;
      $display("FAIL reset_mid_div: allowin=%b valid=%b rf=%h want 1 0 0",
               es_allowin, es_to_ms_valid, es_rf_collect);
    end
    #1;
    reset = 1'b0;
    @(negedge clk);
    send(mk(A_ADD, 1'b0, 32'd1, 32'd2, 1'b0, 1'b1, 5'd1, 32'h0, 32'h0), 8'h00);
    @(negedge clk);
    total++;
    if (es_to_ms_valid !== 1'b1 || es_to_ms_bus[63:32] !== 32'd3 || es_rf_collect[38] !== 1'b0) begin
      bad++;
      $display("FAIL add_after_reset: valid=%b result=%h not_ready=%b want 1 00000003 0",
               es_to_ms_valid, es_to_ms_bus[63:32], es_rf_collect[38]);
    end
    run_div(A_DIV_WU, 32'd1000, 32'd3, 32'd333, "div_after_reset");
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu();
    test_mul();
    test_div();
    test_div_zero_stall();
    test_store();
    test_reset_mid_div();
    ms_allowin = 1'b1;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
